shutter_sched: RTL

SHUTTER_SCHED -- requirements
Module: shutter_sched

---
 rtl/shutter_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shutter_sched.sv
// shutter_sched: active-shutter glasses scheduler.
// Locks onto an RF sync pulse train (rising edge = start of a left frame),
// measures the frame period and drives the left/right shutters with a
// dead band around each eye switch.
module shutter_sched #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned DEAD       = 48,
    parameter int unsigned MIN_PERIOD = 1000,
    parameter int unsigned TIMEOUT    = 65000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_in,
    output logic                 shut_l,
    output logic                 shut_r,
    output logic                 lock,
    output logic [CNT_WIDTH-1:0] period
);

    typedef enum logic [2:0] {
        SEARCH,
        ACQ,
        L_DEAD,
        LEFT,
        R_DEAD,
        RIGHT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEAD_C    = CNT_WIDTH'(DEAD);
    localparam logic [CNT_WIDTH-1:0] DEAD_M1_C = CNT_WIDTH'(DEAD - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH:0]   MIN_P_C   = (CNT_WIDTH + 1)'(MIN_PERIOD);

    state_t               state;
    state_t               state_nxt;
    logic                 sync1;
    logic                 sync2;
    logic                 sync3;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [CNT_WIDTH-1:0] period_nxt;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic [CNT_WIDTH-1:0] half;
    logic [CNT_WIDTH-1:0] half_m1;
    logic [CNT_WIDTH-1:0] half_dead_m1;
    logic                 sync_edge;
    logic                 edge_ok;
    logic                 timeout_hit;

    // cnt+1 is kept one bit wider so the minimum-period test cannot wrap
    assign cnt_inc      = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign half         = period >> 1;
    assign half_m1      = half - ONE_C;
    assign half_dead_m1 = half + DEAD_C - ONE_C;
    assign sync_edge    = sync2 & ~sync3;
    assign edge_ok      = sync_edge & ((state == SEARCH) || (cnt_inc >= MIN_P_C));
    assign timeout_hit  = (cnt == TIMEOUT_C);

    // Two-flop synchronizer for the asynchronous sync input plus an edge delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sync_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Next-state, counter and period selection; a valid edge takes priority over timeout
    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        cnt_nxt    = timeout_hit ? cnt : cnt_inc[CNT_WIDTH-1:0];
        if (edge_ok) begin
            cnt_nxt = '0;
            if (state == SEARCH) begin
                state_nxt = ACQ;
            end else begin
                state_nxt  = L_DEAD;
                period_nxt = cnt_inc[CNT_WIDTH-1:0];
            end
        end else if (timeout_hit && (state != SEARCH)) begin
            state_nxt  = SEARCH;
            period_nxt = '0;
        end else begin
            case (state)
                L_DEAD:  if (cnt == DEAD_M1_C)    state_nxt = LEFT;
                LEFT:    if (cnt == half_m1)      state_nxt = R_DEAD;
                R_DEAD:  if (cnt == half_dead_m1) state_nxt = RIGHT;
                default: state_nxt = state;
            endcase
        end
    end

    // State register with outputs decoded from the next state so they are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEARCH;
            cnt    <= '0;
            period <= '0;
            lock   <= 1'b0;
            shut_l <= 1'b0;
            shut_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            period <= period_nxt;
            case (state_nxt)
                L_DEAD, R_DEAD: begin
                    lock   <= 1'b1;
                    shut_l <= 1'b1;
                    shut_r <= 1'b1;
                end
                LEFT: begin
                    lock   <= 1'b1;
                    shut_l <= 1'b0;
                    shut_r <= 1'b1;
                end
                RIGHT: begin
                    lock   <= 1'b1;
                    shut_l <= 1'b1;
                    shut_r <= 1'b0;
                end
                default: begin
                    lock   <= 1'b0;
                    shut_l <= 1'b0;
                    shut_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
